pc_fetch_controller: RTL

Sequencer for the program counter and instruction-fetch port of the single-cycle/pipelined core. Owns the PC register and the instruction-memory request handshake. Selects the next PC among sequential (pc_adder, PC+4), branch, jump and trap targets, and holds fetch while the pipeline stalls. Sits between the fetch stage's instruction memory and the decode/execute redirect signals.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/pc_adder.sv | 11 +
 rtl/pc_fetch_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sequencer states, default vectors and
// instruction width.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    HOLD
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

endpackage

// File: rtl/pc_adder.sv
// Sequential-path next PC: current_PC + INSTR_BYTES, wrapping modulo 2^32.
module pc_adder
  import cpu_pkg::*;
(
  input  logic [31:0] current_PC,
  output logic [31:0] next_PC
);

  assign next_PC = current_PC + INSTR_BYTES;

endmodule

// File: rtl/pc_fetch_controller.sv
// PC register and instruction-fetch handshake sequencer with prioritised
// redirects (trap > jump > branch > sequential) and a pending-redirect slot.
module pc_fetch_controller
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic [31:0] current_PC,
  output logic        fetch_valid,
  output logic [31:0] fetched_PC,
  output logic        misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic         pend_q, pend_d;
  logic         req_q, req_d;
  logic         fv_q, fv_d;
  logic [31:0]  fpc_q, fpc_d;
  logic         mis_q, mis_d;

  logic [31:0]  pc_seq;
  logic         redir;
  logic [31:0]  redir_tgt;
  logic         redir_mis;

  pc_adder u_pc_adder (
    .current_PC (pc_q),
    .next_PC    (pc_seq)
  );

  // Misaligned jump/branch targets are replaced by the trap vector.
  always_comb begin
    redir     = trap | jump | branch_taken;
    redir_tgt = pc_seq;
    redir_mis = 1'b0;
    if (trap) begin
      redir_tgt = TRAP_VECTOR;
    end else if (jump) begin
      if (jump_target[1:0] != 2'b00) begin
        redir_tgt = TRAP_VECTOR;
        redir_mis = 1'b1;
      end else begin
        redir_tgt = jump_target;
      end
    end else if (branch_taken) begin
      if (branch_target[1:0] != 2'b00) begin
        redir_tgt = TRAP_VECTOR;
        redir_mis = 1'b1;
      end else begin
        redir_tgt = branch_target;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    fv_d       = 1'b0;
    fpc_d      = fpc_q;
    mis_d      = redir_mis;

    unique case (state_q)
      BOOT: begin
        if (redir) pc_d = redir_tgt;
        state_d = REQ;
      end
      HOLD: begin
        if (redir) pc_d = redir_tgt;
        state_d = stall ? HOLD : REQ;
      end
      REQ: begin
        if (!imem_ack) begin
          if (redir) begin
            pend_d     = 1'b1;
            pend_tgt_d = redir_tgt;
          end
        end else begin
          // A same-cycle redirect outranks an earlier pending one; either flushes the fetch.
          if (redir) begin
            pc_d = redir_tgt;
          end else if (pend_q) begin
            pc_d = pend_tgt_q;
          end else begin
            fv_d  = 1'b1;
            fpc_d = pc_q;
            pc_d  = pc_seq;
          end
          pend_d  = 1'b0;
          state_d = stall ? HOLD : REQ;
        end
      end
      default: state_d = BOOT;
    endcase

    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      req_q      <= 1'b0;
      fv_q       <= 1'b0;
      fpc_q      <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      req_q      <= req_d;
      fv_q       <= fv_d;
      fpc_q      <= fpc_d;
      mis_q      <= mis_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign current_PC  = pc_q;
  assign fetch_valid = fv_q;
  assign fetched_PC  = fpc_q;
  assign misaligned  = mis_q;

endmodule
